axis_s2m_frame_scheduler: RTL and testbench

//  Frame-level destination scheduler for a 1-to-NUM AXI-stream S2M interconnect.

---
 rtl/axis_s2m_frame_scheduler_if.sv | 42 ++++
 rtl/axis_s2m_frame_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_axis_s2m_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_s2m_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// axis_s2m_frame_scheduler_if
//   Handshake/bus bundle between the upstream frame source, the frame
//   scheduler and the S2M interconnect.
//   master : scheduler side (drives grant/route/status)
//   slave  : environment side (drives idle flags, requests, end-of-frame)
//   Signals:
//     idle_flag   [NUM]  port may accept a new frame
//     req_valid          upstream frame awaiting a destination
//     req_ready          1-cycle grant pulse, grant_addr valid with it
//     grant_addr  [AW]   last granted port, held between grants
//     route_valid        route FIFO not empty
//     route_addr  [AW]   route FIFO head, drives interconnect addr
//     m_eof       [NUM]  per-port tvalid&tready&tlast
//     fifo_full          route FIFO full
//     err_sticky         protocol error seen, cleared only by reset
// ---------------------------------------------------------------------------
interface axis_s2m_frame_scheduler_if #(
  parameter int NUM = 8
);
  localparam int AW = $clog2(NUM);

  logic [NUM-1:0] idle_flag;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  grant_addr;
  logic           route_valid;
  logic [AW-1:0]  route_addr;
  logic [NUM-1:0] m_eof;
  logic           fifo_full;
  logic           err_sticky;

  modport master (
    input  idle_flag, req_valid, m_eof,
    output req_ready, grant_addr, route_valid, route_addr, fifo_full, err_sticky
  );

  modport slave (
    output idle_flag, req_valid, m_eof,
    input  req_ready, grant_addr, route_valid, route_addr, fifo_full, err_sticky
  );
endinterface

// File: rtl/axis_s2m_frame_scheduler.sv
// ---------------------------------------------------------------------------
// axis_s2m_frame_scheduler
//   Frame-level destination scheduler for a 1-to-NUM AXI-stream S2M
//   interconnect. For each upstream frame it picks an idle output port that
//   still has credit, queues the choice in a route FIFO, and pops the FIFO on
//   the head port's tlast handshake.
//
//   Ports:
//     clock   single clock
//     rst     synchronous, active-high reset
//     bus     axis_s2m_frame_scheduler_if.master (see interface header)
//
//   Parameters: NUM ports (>=2), CREDIT outstanding frames per port (1..15),
//   DEPTH route FIFO entries (power of 2, >=2).
//
//   Build option: define AXIS_SCHED_FIXED_PRIO_EN to select the highest
//   eligible port instead of round-robin (the RR pointer is then removed).
// ---------------------------------------------------------------------------

// Per-port outstanding-frame counter. Saturates at 0 and CREDIT; a
// simultaneous inc/dec leaves it unchanged.
module axis_s2m_credit_cnt #(
  parameter int CREDIT = 2,
  parameter int CW     = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);
  localparam logic [CW-1:0] MAXC = CW'(CREDIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (rst)                              cnt <= '0;
    else if (inc && !dec && cnt != MAXC)  cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign has_credit = (cnt < MAXC);
endmodule

module axis_s2m_frame_scheduler #(
  parameter int NUM    = 8,
  parameter int CREDIT = 2,
  parameter int DEPTH  = 4
) (
  input  logic                            clock,
  input  logic                            rst,
  axis_s2m_frame_scheduler_if.master      bus
);
  localparam int AW = $clog2(NUM);
  localparam int CW = $clog2(CREDIT + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PORT = AW'(NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT} state_t;

  state_t                    state, state_nxt;
  logic [NUM-1:0]            has_credit, eligible, inc_vec, dec_vec, head_oh;
  logic                      any_elig;
  logic [AW-1:0]             pick;
  logic [AW-1:0]             grant_addr_q;
  logic [DEPTH-1:0][AW-1:0]  mem;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [PW:0]               count;
  logic                      push, pop, err_hit, err_q;
  logic                      route_valid, fifo_full;
  logic [AW-1:0]             route_addr;

  // ---- eligibility ----
  assign eligible = bus.idle_flag & has_credit & {NUM{!fifo_full}};
  assign any_elig = |eligible;

  // ---- pick ----
`ifdef AXIS_SCHED_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int i = 0; i < NUM; i++)
      if (eligible[i]) pick = AW'(i);   // highest index wins
  end
`else
  logic [AW-1:0] rr_ptr;

  // Scan offsets from far to near so the nearest eligible port at or after
  // rr_ptr is the last one written.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM) idx = idx - NUM;
      if (eligible[idx]) pick = AW'(idx);
    end
  end

  always_ff @(posedge clock) begin
    if (rst)                   rr_ptr <= '0;
    else if (state == S_GRANT) rr_ptr <= (grant_addr_q == LAST_PORT) ? '0 : grant_addr_q + 1'b1;
  end
`endif

  // ---- FSM ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_nxt = S_ARB;
      S_ARB: begin
        if (!bus.req_valid)  state_nxt = S_IDLE;
        else if (any_elig)   state_nxt = S_GRANT;
      end
      S_GRANT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The pick is captured on the ARB->GRANT edge so grant_addr is already
  // valid during the req_ready pulse.
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= S_IDLE;
      grant_addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ARB && state_nxt == S_GRANT) grant_addr_q <= pick;
    end
  end

  assign push = (state == S_GRANT);

  // ---- route FIFO / pop / error ----
  assign route_valid = (count != '0);
  assign fifo_full   = (count == FULL_CNT);
  assign route_addr  = mem[rd_ptr];
  assign head_oh     = route_valid ? (NUM'(1) << route_addr) : '0;
  assign pop         = route_valid && bus.m_eof[route_addr];
  // Any eof bit outside the head covers both the wrong-port and the
  // multi-bit cases; the head bit itself still pops.
  assign err_hit     = |(bus.m_eof & ~head_oh);

  always_ff @(posedge clock) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= grant_addr_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_hit) err_q <= 1'b1;
    end
  end

  // ---- per-port credit counters ----
  assign inc_vec = push ? (NUM'(1) << grant_addr_q) : '0;
  assign dec_vec = pop  ? head_oh : '0;

  for (genvar i = 0; i < NUM; i++) begin : g_port
    axis_s2m_credit_cnt #(.CREDIT(CREDIT), .CW(CW)) u_cnt (
      .clock      (clock),
      .rst        (rst),
      .inc        (inc_vec[i]),
      .dec        (dec_vec[i]),
      .has_credit (has_credit[i])
    );
  end

  // ---- outputs ----
  assign bus.req_ready   = push;
  assign bus.grant_addr  = grant_addr_q;
  assign bus.route_valid = route_valid;
  assign bus.route_addr  = route_addr;
  assign bus.fifo_full   = fifo_full;
  assign bus.err_sticky  = err_q;
endmodule

// File: tb/tb_axis_s2m_frame_scheduler.sv
module tb_axis_s2m_frame_scheduler;
  localparam int NUM = 8, CREDIT = 2, DEPTH = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  axis_s2m_frame_scheduler_if #(.NUM(NUM)) bus();

  axis_s2m_frame_scheduler #(.NUM(NUM), .CREDIT(CREDIT), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0;

  // ---- reference model: queue of routes, per-port outstanding counts ----
  int q[$];
  int cred[NUM];
  bit m_err, m_rdy, m_open;
  int m_gaddr, m_rr;

  function automatic int pick(logic [NUM-1:0] e);
`ifdef AXIS_SCHED_FIXED_PRIO_EN
    for (int i = NUM - 1; i >= 0; i--) if (e[i]) return i;
`else
    for (int k = 0; k < NUM; k++) if (e[(m_rr + k) % NUM]) return (m_rr + k) % NUM;
`endif
    return -1;
  endfunction

  // Advance the model across one clock edge with this cycle's inputs.
  task automatic model_edge(input logic [NUM-1:0] idle, input logic rv,
                            input logic [NUM-1:0] eof, input logic r);
    logic [NUM-1:0] elig, hoh;
    bit pop, nxt;
    int head, p;
    if (r) begin
      q.delete();
      foreach (cred[i]) cred[i] = 0;
      m_err = 0; m_rdy = 0; m_open = 0; m_gaddr = 0; m_rr = 0;
      return;
    end
    head = (q.size() > 0) ? q[0] : 0;
    hoh  = '0;
    if (q.size() > 0) hoh[head] = 1'b1;
    if ((eof & ~hoh) != '0) m_err = 1;
    pop = (q.size() > 0) && eof[head];
    for (int i = 0; i < NUM; i++) elig[i] = idle[i] && cred[i] < CREDIT && q.size() < DEPTH;
    nxt = 0;
    // a request is seen when no grant is in progress; it is granted one
    // edge after a cycle in which some port is eligible
    if (m_rdy)        m_open = 0;
    else if (!m_open) m_open = rv;
    else if (!rv)     m_open = 0;
    else if (elig != '0) begin
      p = pick(elig);
      nxt = 1; m_gaddr = p; m_open = 0; m_rr = (p + 1) % NUM;
    end
    if (pop) begin
      void'(q.pop_front());
      if (cred[head] > 0) cred[head]--;
    end
    if (m_rdy) begin
      q.push_back(m_gaddr);
      cred[m_gaddr]++;
    end
    m_rdy = nxt;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("req_ready",   bus.req_ready,   m_rdy);
    chk("grant_addr",  bus.grant_addr,  m_gaddr);
    chk("route_valid", bus.route_valid, q.size() > 0);
    if (q.size() > 0) chk("route_addr", bus.route_addr, q[0]);
    chk("fifo_full",   bus.fifo_full,   q.size() == DEPTH);
    chk("err_sticky",  bus.err_sticky,  m_err);
  endtask

  // Called at a negedge: drive inputs, advance model, move to next negedge, compare.
  task automatic step(input logic [NUM-1:0] idle, input logic rv,
                      input logic [NUM-1:0] eof, input logic r);
    bus.idle_flag = idle; bus.req_valid = rv; bus.m_eof = eof; rst = r;
    model_edge(idle, rv, eof, r);
    @(negedge clock);
    cyc++;
    compare_all();
  endtask

  task automatic reset_dut();
    step('0, 1'b0, '0, 1'b1);
    step('0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_grant(input logic [NUM-1:0] idle, input int maxc,
                            output int n, output int addr);
    n = 0;
    do begin
      step(idle, 1'b1, '0, 1'b0);
      n++;
    end while (!bus.req_ready && n < maxc);
    if (!bus.req_ready) chk("grant_timeout", bus.req_ready, 1);
    addr = bus.grant_addr;
  endtask

  task automatic rand_cycle(input bit noise);
    logic [NUM-1:0] idle, eof;
    logic rv;
    idle = NUM'($urandom());
    if ($urandom_range(0, 3) == 0) idle = '1;
    if ($urandom_range(0, 3) == 0) idle &= NUM'($urandom());
    rv  = m_open ? 1'b1 : ($urandom_range(0, 3) != 0);
    eof = '0;
    if (q.size() > 0 && $urandom_range(0, 2) == 0) eof[q[0]] = 1'b1;
    if (noise && $urandom_range(0, 19) == 0) eof[$urandom_range(0, NUM - 1)] = 1'b1;
    step(idle, rv, eof, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, t;
    bus.idle_flag = '0; bus.req_valid = 1'b0; bus.m_eof = '0;
    model_edge('0, 1'b0, '0, 1'b1);
    @(negedge clock);
    reset_dut();
    chk("rst_route_valid", bus.route_valid, 0);
    chk("rst_err",         bus.err_sticky,  0);

    // single port: 2-cycle latency, route visible one cycle after the grant
    wait_grant(8'b0000_0100, 10, n, a);
    chk("t2_latency", n, 2);
    chk("t2_addr",    a, 2);
    step(8'b0000_0100, 1'b0, '0, 1'b0);
    chk("t2_route_valid", bus.route_valid, 1);
    chk("t2_route_addr",  bus.route_addr,  2);

    // round robin
    reset_dut();
    wait_grant('1, 10, n, a); chk("t3_lat0", n, 2); chk("t3_g0", a, 0);
    wait_grant('1, 10, n, a); chk("t3_lat1", n, 3); chk("t3_g1", a, 1);
    wait_grant('1, 10, n, a); chk("t3_lat2", n, 3); chk("t3_g2", a, 2);
    step('1, 1'b0, 8'b0000_0001, 1'b0);
    chk("t3_pop_head", bus.route_addr, 1);

    // credit exhaustion on port 5
    reset_dut();
    wait_grant(8'b0010_0000, 10, n, a); chk("t4_g0", a, 5);
    wait_grant(8'b0010_0000, 10, n, a); chk("t4_g1", a, 5);
    for (int i = 0; i < 6; i++) begin
      step(8'b0010_0000, 1'b1, '0, 1'b0);
      chk("t4_stall", bus.req_ready, 0);
    end
    step(8'b0010_0000, 1'b1, 8'b0010_0000, 1'b0);
    chk("t4_no_early", bus.req_ready, 0);
    step(8'b0010_0000, 1'b1, '0, 1'b0);
    chk("t4_resume", bus.req_ready, 1);
    chk("t4_addr",   bus.grant_addr, 5);

    // FIFO full blocks grants
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      wait_grant('1, 10, n, a);
      chk("t5_g", a, i);
    end
    for (int i = 0; i < 5; i++) begin
      step('1, 1'b1, '0, 1'b0);
      chk("t5_full",  bus.fifo_full, 1);
      chk("t5_block", bus.req_ready, 0);
    end
    step('1, 1'b1, 8'b0000_0001, 1'b0);
    chk("t5_unfull", bus.fifo_full, 0);
    step('1, 1'b1, '0, 1'b0);
    chk("t5_resume", bus.req_ready, 1);
    chk("t5_addr",   bus.grant_addr, 4);

    // protocol errors
    reset_dut();
    wait_grant(8'b0000_0010, 10, n, a); chk("t6_g", a, 1);
    step('0, 1'b0, '0, 1'b0);
    step('0, 1'b0, 8'b0000_1000, 1'b0);
    chk("t6_err",        bus.err_sticky,  1);
    chk("t6_nopop",      bus.route_valid, 1);
    chk("t6_head",       bus.route_addr,  1);
    step('0, 1'b0, 8'b0000_1010, 1'b0);
    chk("t6_multi_pop",  bus.route_valid, 0);
    chk("t6_err_hold",   bus.err_sticky,  1);

    // selection policy on a sparse idle mask
    reset_dut();
    wait_grant(8'b0010_0110, 10, n, a);
`ifdef AXIS_SCHED_FIXED_PRIO_EN
    chk("t6_prio0", a, 5);
`else
    chk("t6_rr0", a, 1);
`endif
    wait_grant(8'b0010_0110, 10, n, a);
`ifdef AXIS_SCHED_FIXED_PRIO_EN
    chk("t6_prio1", a, 5);
`else
    chk("t6_rr1", a, 2);
`endif

    // randomized traffic against the model
    reset_dut();
    for (int i = 0; i < 2500; i++) rand_cycle(1'b0);
    for (int i = 0; i < 400; i++)  rand_cycle(1'b1);

    // reset landing on a grant cycle
    t = 0;
    while (!m_rdy && t < 200) begin rand_cycle(1'b0); t++; end
    chk("t1_found_grant", bus.req_ready, 1);
    step('1, 1'b1, '0, 1'b1);
    chk("t1_req_ready",   bus.req_ready,   0);
    chk("t1_grant_addr",  bus.grant_addr,  0);
    chk("t1_route_valid", bus.route_valid, 0);
    chk("t1_route_addr",  bus.route_addr,  0);
    chk("t1_fifo_full",   bus.fifo_full,   0);
    chk("t1_err",         bus.err_sticky,  0);
    // cleared credits: port 5 takes CREDIT frames again
    wait_grant(8'b0010_0000, 10, n, a); chk("t1_cred0", a, 5);
    wait_grant(8'b0010_0000, 10, n, a); chk("t1_cred1", a, 5);
    for (int i = 0; i < 300; i++) rand_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
